// File: rtl/ysyx_pkg.sv
// ysyx_pkg: shared front-end types and widths for the redirect controller
`ifndef YSYX_W_WIDTH
`define YSYX_W_WIDTH 32
`endif
`ifndef YSYX_PC_INIT
`define YSYX_PC_INIT 32'h8000_0000
`endif
package ysyx_pkg;
    localparam int SPEC_W = 3;
    typedef enum logic [1:0] {BOOT, IDLE, FLUSH, REDIRECT} redirect_state_t;
    typedef enum logic [1:0] {SRC_TRAP, SRC_FLUSH, SRC_MISPRED} redirect_src_t;
endpackage

// File: rtl/ysyx_redirect_ctrl_if.sv
// ysyx_redirect_ctrl_if: redirect target handshake toward the PC/IFU
interface ysyx_redirect_ctrl_if #(
    parameter int DATA_W = `YSYX_W_WIDTH
);
    logic              redirect_valid_o;
    logic [DATA_W-1:0] redirect_pc_o;
    logic              redirect_ready_i;
    modport master (output redirect_valid_o, output redirect_pc_o, input redirect_ready_i);
    modport slave (input redirect_valid_o, input redirect_pc_o, output redirect_ready_i);
endinterface

// File: rtl/ysyx_sat_counter.sv
// ysyx_sat_counter: up/down counter that saturates at both ends, with clear
module ysyx_sat_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         up,
    input  logic         dn,
    output logic [W-1:0] cnt,
    output logic [W-1:0] cnt_d
);
    // Clear wins; opposing events cancel; both ends hold instead of wrapping.
    always_comb cnt_d = clr ? '0 :
                        (up && !dn && cnt != '1) ? cnt + 1'b1 :
                        (dn && !up && cnt != '0) ? cnt - 1'b1 : cnt;
    // Count register.
    always_ff @(posedge clk) cnt <= rst ? '0 : cnt_d;
endmodule

// File: rtl/ysyx_redirect_ctrl.sv
// ysyx_redirect_ctrl: arbitrates redirects, squashes the pipe and hands the target to the PC/IFU
module ysyx_redirect_ctrl #(
    parameter int                DATA_W  = `YSYX_W_WIDTH,
    parameter logic [DATA_W-1:0] PC_INIT = `YSYX_PC_INIT,
    parameter int                SPEC_W  = ysyx_pkg::SPEC_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmt_trap_valid,
    input  logic [DATA_W-1:0]    cmt_trap_tvec,
    input  logic                 cmt_flush_valid,
    input  logic [DATA_W-1:0]    cmt_flush_pc,
    input  logic                 exu_mispred_valid,
    input  logic [DATA_W-1:0]    exu_mispred_npc,
    input  logic                 exu_br_resolve,
    input  logic                 ifu_br_issue,
    ysyx_redirect_ctrl_if.master rd,
    output logic                 flush_o,
    output logic                 stall_ifu_o,
    output logic [SPEC_W-1:0]    spec_cnt_o,
    output logic [31:0]          redirect_cnt_o
);
    import ysyx_pkg::*;
    localparam logic [SPEC_W-1:0] SPEC_MAX = '1;
    redirect_state_t   state_q, state_d;
    redirect_src_t     src;
    logic              cmt_req, hs, lat;
    logic              valid_d, flush_d, stall_d;
    logic [DATA_W-1:0] tgt, pc_d;
    logic [31:0]       cnt_d;
    logic [SPEC_W-1:0] spec_d;
    // Inline priority: trap beats serialising flush beats mispredict.
    always_comb begin
        cmt_req = cmt_trap_valid | cmt_flush_valid;
        src     = cmt_trap_valid ? SRC_TRAP : cmt_flush_valid ? SRC_FLUSH : SRC_MISPRED;
        tgt     = src == SRC_TRAP ? cmt_trap_tvec : src == SRC_FLUSH ? cmt_flush_pc : exu_mispred_npc;
    end
    // Next state: mispredicts only count in IDLE, commit requests override FLUSH/REDIRECT.
    always_comb begin
        hs      = state_q == REDIRECT && rd.redirect_ready_i;
        lat     = state_q == IDLE ? (cmt_req | exu_mispred_valid) : (state_q != BOOT) && cmt_req;
        state_d = lat ? FLUSH :
                  state_q == BOOT ? (rd.redirect_ready_i ? IDLE : BOOT) :
                  state_q == FLUSH ? REDIRECT :
                  hs ? IDLE : state_q;
    end
    // Output values for the next cycle, derived from the next state so every output is a flop.
    always_comb begin
        valid_d = state_d == BOOT || state_d == REDIRECT;
        flush_d = state_d == FLUSH;
        pc_d    = lat ? tgt : rd.redirect_pc_o;
        stall_d = state_d != IDLE || spec_d == SPEC_MAX;
        cnt_d   = redirect_cnt_o + 32'(hs);
    end
    // State and registered outputs; reset drops any latched target back to the boot PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q             <= BOOT;
            rd.redirect_valid_o <= 1'b1;
            rd.redirect_pc_o    <= PC_INIT;
            flush_o             <= 1'b0;
            stall_ifu_o         <= 1'b1;
            redirect_cnt_o      <= '0;
        end else begin
            state_q             <= state_d;
            rd.redirect_valid_o <= valid_d;
            rd.redirect_pc_o    <= pc_d;
            flush_o             <= flush_d;
            stall_ifu_o         <= stall_d;
            redirect_cnt_o      <= cnt_d;
        end
    end
    ysyx_sat_counter #(.W(SPEC_W)) u_spec (
        .clk   (clk),
        .rst   (rst),
        .clr   (state_d == FLUSH),
        .up    (ifu_br_issue),
        .dn    (exu_br_resolve),
        .cnt   (spec_cnt_o),
        .cnt_d (spec_d)
    );
endmodule
